// File: rtl/mem_addr_pkg.sv
// rtl/mem_addr_pkg.sv - shared FSM state type and width helper for mem_addr_unit
package mem_addr_pkg;

  // Access sequencer states; the encodings are fixed so debug probes read consistently.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2,
    ST_ERR  = 2'd3
  } state_e;

  // BurstLen carries (words - 1); a single-word unit still needs one bit on the port.
  function automatic int burst_len_w(input int burst_max);
    return (burst_max > 1) ? $clog2(burst_max) : 1;
  endfunction

endpackage

// File: rtl/wait_timer.sv
// rtl/wait_timer.sv - per-word acknowledge wait counter with expiry flag
module wait_timer #(
  parameter int MAX_WAIT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int CNT_W = $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(MAX_WAIT);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Count unacknowledged cycles; saturate at the limit so the flag stays stable.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != LIMIT)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Counter register, cleared asynchronously with the rest of the unit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = (cnt_q == LIMIT);

endmodule

// File: rtl/mem_addr_unit.sv
// rtl/mem_addr_unit.sv - memory address register with burst access sequencer and timeout
module mem_addr_unit
  import mem_addr_pkg::*;
#(
  parameter int ADDR_W    = 9,
  parameter int DATA_W    = 32,
  parameter int BURST_MAX = 4,
  parameter int MAX_WAIT  = 15
) (
  input  logic                                clk,
  input  logic                                Clear,
  input  logic                                MARIn,
  input  logic                                MARInc,
  input  logic [DATA_W-1:0]                   BusMuxOut,
  input  logic                                ReadStart,
  input  logic                                WriteStart,
  input  logic [burst_len_w(BURST_MAX)-1:0]   BurstLen,
  input  logic                                MemAck,
  output logic [ADDR_W-1:0]                   AddressOut,
  output logic                                MemReq,
  output logic                                MemWe,
  output logic                                Busy,
  output logic                                Done,
  output logic                                Timeout
);

  localparam int BL_W = burst_len_w(BURST_MAX);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              we_q, we_d;
  logic [BL_W-1:0]   remaining_q, remaining_d;
  logic              timeout_q, timeout_d;
  logic              wait_expired;
  logic              unused_bus;

  // Only the low ADDR_W bits of the bus address the memory.
  assign unused_bus = ^BusMuxOut;

  // The wait counter runs only while a word is outstanding and restarts on every ack.
  wait_timer #(
    .MAX_WAIT (MAX_WAIT)
  ) u_wait_timer (
    .clk       (clk),
    .rst       (Clear),
    .clr_i     ((state_q != ST_REQ) || MemAck),
    .en_i      (state_q == ST_REQ),
    .expired_o (wait_expired)
  );

  // Next-state logic: address updates and starts are accepted only in IDLE.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    we_d        = we_q;
    remaining_d = remaining_q;
    timeout_d   = timeout_q;
    case (state_q)
      ST_IDLE: begin
        if (MARIn) begin
          addr_d = BusMuxOut[ADDR_W-1:0];
        end else if (MARInc) begin
          addr_d = addr_q + ADDR_W'(1);
        end
        if (ReadStart || WriteStart) begin
          we_d        = ~ReadStart;
          remaining_d = BurstLen;
          timeout_d   = 1'b0;
          state_d     = ST_REQ;
        end
      end
      ST_REQ: begin
        // An ack on the expiry edge still wins over the timeout.
        if (MemAck) begin
          addr_d = addr_q + ADDR_W'(1);
          if (remaining_q == '0) begin
            state_d = ST_DONE;
          end else begin
            remaining_d = remaining_q - BL_W'(1);
          end
        end else if (wait_expired) begin
          timeout_d = 1'b1;
          state_d   = ST_ERR;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      ST_ERR:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers; Clear aborts any access immediately.
  always_ff @(posedge clk or posedge Clear) begin
    if (Clear) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      we_q        <= 1'b0;
      remaining_q <= '0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      we_q        <= we_d;
      remaining_q <= remaining_d;
      timeout_q   <= timeout_d;
    end
  end

  assign AddressOut = addr_q;
  assign MemReq     = (state_q == ST_REQ);
  assign MemWe      = (state_q == ST_REQ) && we_q;
  assign Busy       = (state_q != ST_IDLE);
  assign Done       = (state_q == ST_DONE);
  assign Timeout    = timeout_q;

endmodule

// File: tb/tb_mem_addr_unit.sv
// tb/tb_mem_addr_unit.sv - self-checking bench for mem_addr_unit
module tb_mem_addr_unit;

  localparam int ADDR_W    = 9;
  localparam int DATA_W    = 32;
  localparam int BURST_MAX = 4;
  localparam int MAX_WAIT  = 15;

  logic              clk = 1'b0;
  logic              Clear, MARIn, MARInc, ReadStart, WriteStart, MemAck;
  logic [DATA_W-1:0] BusMuxOut;
  logic [1:0]        BurstLen;
  logic [ADDR_W-1:0] AddressOut;
  logic              MemReq, MemWe, Busy, Done, Timeout;

  int checks = 0;
  int errors = 0;
  int dly[16];

  always #5 clk = ~clk;

  mem_addr_unit #(
    .ADDR_W    (ADDR_W),
    .DATA_W    (DATA_W),
    .BURST_MAX (BURST_MAX),
    .MAX_WAIT  (MAX_WAIT)
  ) dut (
    .clk        (clk),
    .Clear      (Clear),
    .MARIn      (MARIn),
    .MARInc     (MARInc),
    .BusMuxOut  (BusMuxOut),
    .ReadStart  (ReadStart),
    .WriteStart (WriteStart),
    .BurstLen   (BurstLen),
    .MemAck     (MemAck),
    .AddressOut (AddressOut),
    .MemReq     (MemReq),
    .MemWe      (MemWe),
    .Busy       (Busy),
    .Done       (Done),
    .Timeout    (Timeout)
  );

  typedef struct {
    logic        marin;
    logic        marinc;
    logic [31:0] bus;
    logic [8:0]  exp_addr;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One complete access planned at transaction level: word k is acked dly[k]
  // cycles after its request appears; a delay above MAX_WAIT means no ack.
  task automatic run_access(input logic [8:0] addr, input bit wr, input bit both, input int bl);
    logic [8:0] a;
    logic [8:0] fin;
    bit         exp_we;
    exp_we = wr && !both;
    MARIn = 1'b1;
    BusMuxOut = $urandom();
    BusMuxOut[8:0] = addr;
    tick();
    MARIn = 1'b0;
    check("load_addr", AddressOut, addr);
    ReadStart  = !wr || both;
    WriteStart = wr || both;
    BurstLen   = bl[1:0];
    tick();
    ReadStart  = 1'b0;
    WriteStart = 1'b0;
    check("start_clears_timeout", Timeout, 0);
    for (int k = 0; k <= bl; k++) begin
      a = addr + 9'(k);
      for (int c = 0; c <= MAX_WAIT; c++) begin
        check("req_high", MemReq, 1);
        check("req_we", MemWe, exp_we);
        check("req_addr", AddressOut, a);
        check("req_busy", Busy, 1);
        check("req_no_done", Done, 0);
        MemAck = (c == dly[k]);
        tick();
        MemAck = 1'b0;
        if (c == dly[k]) break;
      end
      if (dly[k] > MAX_WAIT) begin
        check("err_req_low", MemReq, 0);
        check("err_timeout", Timeout, 1);
        check("err_busy", Busy, 1);
        check("err_no_done", Done, 0);
        check("err_addr_kept", AddressOut, a);
        tick();
        check("post_err_idle", Busy, 0);
        check("post_err_timeout_sticky", Timeout, 1);
        check("post_err_no_done", Done, 0);
        check("post_err_addr", AddressOut, a);
        return;
      end
    end
    fin = addr + 9'(bl) + 9'd1;
    check("done_pulse", Done, 1);
    check("done_req_low", MemReq, 0);
    check("done_busy", Busy, 1);
    check("done_addr", AddressOut, fin);
    tick();
    check("done_single_cycle", Done, 0);
    check("final_idle", Busy, 0);
    check("final_addr", AddressOut, fin);
    check("final_no_timeout", Timeout, 0);
  endtask

  initial begin
    Clear = 1'b1; MARIn = 1'b0; MARInc = 1'b0; ReadStart = 1'b0; WriteStart = 1'b0;
    MemAck = 1'b0; BusMuxOut = '0; BurstLen = '0;
    tick();
    tick();
    check("rst_addr", AddressOut, 0);
    check("rst_req", MemReq, 0);
    check("rst_we", MemWe, 0);
    check("rst_busy", Busy, 0);
    check("rst_done", Done, 0);
    check("rst_timeout", Timeout, 0);
    Clear = 1'b0;

    // Address register vectors in IDLE.
    vecs[0] = '{1'b1, 1'b0, 32'hFFFF_F1FF, 9'h1FF};
    vecs[1] = '{1'b0, 1'b1, 32'h0000_0000, 9'h000};
    vecs[2] = '{1'b0, 1'b1, 32'h0000_0000, 9'h001};
    vecs[3] = '{1'b0, 1'b0, 32'h0000_0123, 9'h001};
    vecs[4] = '{1'b1, 1'b1, 32'h0000_00AA, 9'h0AA};
    vecs[5] = '{1'b1, 1'b0, 32'h8000_01FF, 9'h1FF};
    vecs[6] = '{1'b0, 1'b1, 32'h0000_0000, 9'h000};
    vecs[7] = '{1'b1, 1'b0, 32'h1234_5E05, 9'h005};
    for (int i = 0; i < 8; i++) begin
      MARIn = vecs[i].marin;
      MARInc = vecs[i].marinc;
      BusMuxOut = vecs[i].bus;
      tick();
      check($sformatf("vec%0d_addr", i), AddressOut, vecs[i].exp_addr);
      check($sformatf("vec%0d_idle", i), Busy, 0);
    end
    MARIn = 1'b0;
    MARInc = 1'b0;

    // Single read, ack two cycles after the request rises.
    dly[0] = 2;
    run_access(9'h010, 1'b0, 1'b0, 0);

    // Wrapping burst write, ack every cycle.
    for (int k = 0; k < 4; k++) dly[k] = 0;
    run_access(9'h1FE, 1'b1, 1'b0, 3);

    // Timeout, then ack exactly at the limit (its start clears Timeout).
    dly[0] = MAX_WAIT + 1;
    run_access(9'h0C3, 1'b0, 1'b0, 0);
    dly[0] = MAX_WAIT;
    run_access(9'h0C3, 1'b0, 1'b0, 0);

    // Simultaneous read and write starts: read wins.
    dly[0] = 1; dly[1] = 0;
    run_access(9'h07F, 1'b1, 1'b1, 1);

    // Timeout in the second word of a burst, then Clear drops the sticky flag.
    dly[0] = 0; dly[1] = MAX_WAIT + 1;
    run_access(9'h1FF, 1'b1, 1'b0, 3);
    Clear = 1'b1;
    #1;
    check("clear_timeout", Timeout, 0);
    check("clear_addr", AddressOut, 0);
    tick();
    Clear = 1'b0;

    // Start coincident with MARInc, then inputs ignored while busy.
    MARIn = 1'b1; BusMuxOut = 32'h0000_0050;
    tick();
    MARIn = 1'b0;
    MARInc = 1'b1; ReadStart = 1'b1; BurstLen = 2'd0;
    tick();
    MARInc = 1'b0; ReadStart = 1'b0;
    check("coinc_addr", AddressOut, 9'h051);
    check("coinc_req", MemReq, 1);
    check("coinc_we", MemWe, 0);
    MARIn = 1'b1; MARInc = 1'b1; BusMuxOut = 32'h0000_01AA; WriteStart = 1'b1; BurstLen = 2'd3;
    tick();
    MARIn = 1'b0; MARInc = 1'b0; WriteStart = 1'b0;
    check("busy_ignore_addr", AddressOut, 9'h051);
    check("busy_ignore_we", MemWe, 0);
    MemAck = 1'b1;
    tick();
    check("coinc_done", Done, 1);
    check("coinc_final_addr", AddressOut, 9'h052);
    tick();
    check("ack_in_done_ignored", AddressOut, 9'h052);
    check("ack_in_done_idle", Busy, 0);
    tick();
    MemAck = 1'b0;
    check("ack_in_idle_ignored", AddressOut, 9'h052);
    check("ack_in_idle_no_req", MemReq, 0);

    // Clear during the second word of a four-word burst.
    MARIn = 1'b1; BusMuxOut = 32'h0000_0100;
    tick();
    MARIn = 1'b0; WriteStart = 1'b1; BurstLen = 2'd3;
    tick();
    WriteStart = 1'b0; MemAck = 1'b1;
    tick();
    MemAck = 1'b0;
    check("mid_burst_addr", AddressOut, 9'h101);
    check("mid_burst_req", MemReq, 1);
    #2;
    Clear = 1'b1;
    #1;
    check("async_clr_req", MemReq, 0);
    check("async_clr_addr", AddressOut, 0);
    check("async_clr_busy", Busy, 0);
    check("async_clr_we", MemWe, 0);
    @(posedge clk);
    #1;
    Clear = 1'b0;
    MemAck = 1'b1;
    tick();
    MemAck = 1'b0;
    check("no_resume_busy", Busy, 0);
    check("no_resume_req", MemReq, 0);
    check("no_resume_done", Done, 0);
    check("no_resume_addr", AddressOut, 0);

    // Randomized accesses against the transaction plan.
    for (int t = 0; t < 12; t++) begin
      int bl;
      bl = $urandom_range(0, 3);
      for (int k = 0; k < 4; k++) begin
        case ($urandom_range(0, 9))
          0:       dly[k] = MAX_WAIT + 1;
          1:       dly[k] = MAX_WAIT;
          default: dly[k] = $urandom_range(0, 4);
        endcase
      end
      run_access(9'($urandom_range(0, 511)), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 5) == 0), bl);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
